// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, opcode
// classes and the ALU function codes driven on ALU_Op.
package ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_EXEC   = 4'd2,
    ST_WB     = 4'd3,
    ST_ADDR   = 4'd4,
    ST_MEM    = 4'd5,
    ST_BRANCH = 4'd6,
    ST_HALT   = 4'd7,
    ST_FAULT  = 4'd8
  } state_e;

  localparam logic [3:0] OP_HALT   = 4'b1111;
  localparam logic [3:0] OP_BRANCH = 4'b1001;
  localparam logic [3:0] OP_LOAD   = 4'b1000;
  localparam logic [3:0] OP_STORE  = 4'b1010;

  // ALU function codes; the _FOR_ names give the EXEC opcode selecting them
  localparam logic [2:0] ALU_OP_ADD      = 3'd1;
  localparam logic [2:0] ALU_OP_SUB      = 3'd6;
  localparam logic [2:0] ALU_OP_FOR_0010 = 3'd2;
  localparam logic [2:0] ALU_OP_FOR_0100 = 3'd6;
  localparam logic [2:0] ALU_OP_FOR_0101 = 3'd3;
  localparam logic [2:0] ALU_OP_FOR_0110 = 3'd5;
  localparam logic [2:0] ALU_OP_FOR_1011 = 3'd0;
  localparam logic [2:0] ALU_OP_FOR_1100 = 3'd4;
  localparam logic [2:0] ALU_OP_FOR_1101 = 3'd7;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational Op_Code -> ALU function table used while in EXEC.
// Opcodes outside the table fall back to add.
module alu_op_decode
  import ctrl_pkg::*;
(
  input  logic [3:0] op_code_i,
  output logic [2:0] alu_op_o
);

  // opcode to ALU function lookup
  always_comb begin
    alu_op_o = ALU_OP_ADD;
    case (op_code_i)
      4'b0010: alu_op_o = ALU_OP_FOR_0010;
      4'b0100: alu_op_o = ALU_OP_FOR_0100;
      4'b0101: alu_op_o = ALU_OP_FOR_0101;
      4'b0110: alu_op_o = ALU_OP_FOR_0110;
      4'b1011: alu_op_o = ALU_OP_FOR_1011;
      4'b1100: alu_op_o = ALU_OP_FOR_1100;
      4'b1101: alu_op_o = ALU_OP_FOR_1101;
      default: alu_op_o = ALU_OP_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle CPU control FSM: fetch/decode/execute sequencing, memory
// handshake with a per-access timeout, retire counter and sticky HALT/FAULT.
module multi_cycle_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  Op_Code,
  input  logic        Zero,
  input  logic        Mem_Ready,
  output logic        Mem_Req,
  output logic        Mem_Read,
  output logic        Mem_Write,
  output logic        IorD,
  output logic        IR_Write,
  output logic        PC_Write,
  output logic        Reg_Write,
  output logic [2:0]  ALU_Op,
  output logic [3:0]  State,
  output logic        Halted,
  output logic        Fault,
  output logic [15:0] Instr_Count
);

  // A request faults on its MEM_TIMEOUT-th consecutive cycle without
  // Mem_Ready; Mem_Ready in that same cycle still completes it.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [15:0] count_q, count_d;
  logic [2:0]  exec_alu_op;
  logic        retire;
  logic        timeout;
  logic        in_mem_wait;

  alu_op_decode u_alu_op_decode (
    .op_code_i (Op_Code),
    .alu_op_o  (exec_alu_op)
  );

  assign in_mem_wait = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign timeout     = !Mem_Ready && (wait_q == WAIT_LAST);

  // state, wait counter and retire counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      wait_q  <= 8'd0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      count_q <= count_d;
    end
  end

  // next-state logic and retire strobe
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (Mem_Ready)    state_d = ST_DECODE;
        else if (timeout) state_d = ST_FAULT;
        else              state_d = ST_FETCH;
      end
      ST_DECODE: begin
        case (Op_Code)
          OP_HALT:           state_d = ST_HALT;
          OP_BRANCH:         state_d = ST_BRANCH;
          OP_LOAD, OP_STORE: state_d = ST_ADDR;
          default:           state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: state_d = ST_WB;
      ST_WB: begin
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_ADDR: state_d = ST_MEM;
      ST_MEM: begin
        if (Mem_Ready) begin
          if (Op_Code == OP_STORE) begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (timeout) begin
          state_d = ST_FAULT;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_BRANCH: begin
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT:  state_d = ST_HALT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase
  end

  // wait counter restarts on every state change, counts idle request cycles
  always_comb begin
    if (state_d != state_q)           wait_d = 8'd0;
    else if (in_mem_wait && !Mem_Ready) wait_d = wait_q + 8'd1;
    else                              wait_d = wait_q;
  end

  // saturating retired-instruction counter
  always_comb begin
    if (retire && (count_q != 16'hFFFF)) count_d = count_q + 16'd1;
    else                                 count_d = count_q;
  end

  // Moore output decode; everything quiet while rst is high
  always_comb begin
    Mem_Req   = 1'b0;
    Mem_Read  = 1'b0;
    Mem_Write = 1'b0;
    IorD      = 1'b0;
    IR_Write  = 1'b0;
    PC_Write  = 1'b0;
    Reg_Write = 1'b0;
    ALU_Op    = ALU_OP_ADD;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          Mem_Req  = 1'b1;
          Mem_Read = 1'b1;
          IR_Write = Mem_Ready;
          PC_Write = Mem_Ready;
        end
        ST_EXEC:   ALU_Op = exec_alu_op;
        ST_WB:     Reg_Write = 1'b1;
        ST_ADDR:   ALU_Op = ALU_OP_ADD;
        ST_MEM: begin
          Mem_Req   = 1'b1;
          IorD      = 1'b1;
          Mem_Read  = (Op_Code != OP_STORE);
          Mem_Write = (Op_Code == OP_STORE);
        end
        ST_BRANCH: begin
          ALU_Op   = ALU_OP_SUB;
          PC_Write = Zero;
        end
        default: ALU_Op = ALU_OP_ADD;
      endcase
    end else begin
      ALU_Op = ALU_OP_ADD;
    end
  end

  assign State       = state_q;
  assign Halted      = (state_q == ST_HALT);
  assign Fault       = (state_q == ST_FAULT);
  assign Instr_Count = count_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed self-checking bench for multi_cycle_controller: instruction
// classes, memory wait/timeout boundary, HALT, FAULT and mid-access reset.
module tb_multi_cycle_controller;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, Zero, Mem_Ready;
  logic [3:0]  Op_Code;
  logic        Mem_Req, Mem_Read, Mem_Write, IorD;
  logic        IR_Write, PC_Write, Reg_Write;
  logic [2:0]  ALU_Op;
  logic [3:0]  State;
  logic        Halted, Fault;
  logic [15:0] Instr_Count;

  int n_checks = 0;
  int n_pass   = 0;
  int req_seen;

  multi_cycle_controller #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .Op_Code(Op_Code), .Zero(Zero), .Mem_Ready(Mem_Ready),
    .Mem_Req(Mem_Req), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .IorD(IorD),
    .IR_Write(IR_Write), .PC_Write(PC_Write), .Reg_Write(Reg_Write),
    .ALU_Op(ALU_Op), .State(State), .Halted(Halted), .Fault(Fault),
    .Instr_Count(Instr_Count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // advance one clock; inputs are then changed 2 time units after the edge
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // FETCH cycle with immediate Mem_Ready; returns in DECODE with Mem_Ready low
  task automatic fetch_ok(input logic [3:0] op);
    Op_Code = op; Mem_Ready = 1'b1;
    #1;
    check("fetch_state", 32'(State), 32'(ST_FETCH));
    check("fetch_irw", 32'(IR_Write), 32'd1);
    check("fetch_pcw", 32'(PC_Write), 32'd1);
    cyc();
    Mem_Ready = 1'b0;
  endtask

  // complete ALU instruction: FETCH, DECODE, EXEC, WB, back to FETCH
  task automatic run_alu(input logic [3:0] op, input logic [2:0] exp_alu, input logic [15:0] exp_cnt);
    fetch_ok(op);
    #1 check("alu_decode", 32'(State), 32'(ST_DECODE));
    cyc();
    #1 check("alu_exec", 32'(State), 32'(ST_EXEC));
    check("alu_op", 32'(ALU_Op), 32'(exp_alu));
    check("alu_regw_exec", 32'(Reg_Write), 32'd0);
    cyc();
    #1 check("alu_wb", 32'(State), 32'(ST_WB));
    check("alu_regw_wb", 32'(Reg_Write), 32'd1);
    cyc();
    #1 check("alu_back_fetch", 32'(State), 32'(ST_FETCH));
    check("alu_regw_after", 32'(Reg_Write), 32'd0);
    check("alu_count", 32'(Instr_Count), 32'(exp_cnt));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; Zero = 1'b0; Mem_Ready = 1'b0; Op_Code = 4'd0;
    cyc();
    cyc();
    // during reset: enables quiet even with Mem_Ready high
    Mem_Ready = 1'b1;
    #1;
    check("rst_memreq", 32'(Mem_Req), 32'd0);
    check("rst_irw", 32'(IR_Write), 32'd0);
    check("rst_aluop", 32'(ALU_Op), 32'd1);
    Mem_Ready = 1'b0;
    rst = 1'b0;
    #1;
    check("post_rst_state", 32'(State), 32'(ST_FETCH));
    check("post_rst_memreq", 32'(Mem_Req), 32'd1);
    check("post_rst_memread", 32'(Mem_Read), 32'd1);
    check("post_rst_iord", 32'(IorD), 32'd0);
    check("post_rst_count", 32'(Instr_Count), 32'd0);
    check("post_rst_halted", 32'(Halted), 32'd0);
    check("post_rst_fault", 32'(Fault), 32'd0);
    cyc();

    // ALU class, table entries and fallback
    run_alu(4'b0100, 3'd6, 16'd1);
    run_alu(4'b0010, 3'd2, 16'd2);
    run_alu(4'b1101, 3'd7, 16'd3);
    run_alu(4'b0111, 3'd1, 16'd4);

    // load, Mem_Ready arrives on 4th MEM cycle: 8 cycles total
    fetch_ok(OP_LOAD);
    #1 check("ld_decode", 32'(State), 32'(ST_DECODE));
    cyc();
    #1 check("ld_addr", 32'(State), 32'(ST_ADDR));
    check("ld_addr_alu", 32'(ALU_Op), 32'd1);
    cyc();
    for (int i = 0; i < 4; i++) begin
      Mem_Ready = (i == 3);
      #1;
      check("ld_mem_state", 32'(State), 32'(ST_MEM));
      check("ld_mem_req", 32'(Mem_Req), 32'd1);
      check("ld_mem_iord", 32'(IorD), 32'd1);
      check("ld_mem_rd", 32'(Mem_Read), 32'd1);
      check("ld_mem_wr", 32'(Mem_Write), 32'd0);
      cyc();
    end
    Mem_Ready = 1'b0;
    #1 check("ld_wb", 32'(State), 32'(ST_WB));
    check("ld_regw", 32'(Reg_Write), 32'd1);
    cyc();
    #1 check("ld_fetch", 32'(State), 32'(ST_FETCH));
    check("ld_count", 32'(Instr_Count), 32'd5);

    // store, Mem_Ready high through DECODE/ADDR must not shortcut anything
    fetch_ok(OP_STORE);
    Mem_Ready = 1'b1;
    #1 check("st_decode", 32'(State), 32'(ST_DECODE));
    cyc();
    #1 check("st_addr", 32'(State), 32'(ST_ADDR));
    cyc();
    #1 check("st_mem", 32'(State), 32'(ST_MEM));
    check("st_mem_wr", 32'(Mem_Write), 32'd1);
    check("st_mem_rd", 32'(Mem_Read), 32'd0);
    cyc();
    Mem_Ready = 1'b0;
    #1 check("st_fetch", 32'(State), 32'(ST_FETCH));
    check("st_count", 32'(Instr_Count), 32'd6);

    // branches: taken then not taken
    for (int z = 1; z >= 0; z--) begin
      fetch_ok(OP_BRANCH);
      cyc();
      Zero = z[0];
      #1 check("br_state", 32'(State), 32'(ST_BRANCH));
      check("br_alu", 32'(ALU_Op), 32'd6);
      check("br_pcw", 32'(PC_Write), 32'(z));
      cyc();
      Zero = 1'b0;
      #1 check("br_fetch", 32'(State), 32'(ST_FETCH));
      check("br_count", 32'(Instr_Count), 32'(8 - z));
    end

    // Mem_Ready on the 15th wait cycle completes the fetch
    Op_Code = 4'b0000;
    for (int i = 0; i < 14; i++) cyc();
    Mem_Ready = 1'b1;
    #1 check("to_edge_state", 32'(State), 32'(ST_FETCH));
    check("to_edge_irw", 32'(IR_Write), 32'd1);
    cyc();
    Mem_Ready = 1'b0;
    #1 check("to_edge_decode", 32'(State), 32'(ST_DECODE));
    cyc();
    cyc();
    cyc();
    #1 check("to_edge_count", 32'(Instr_Count), 32'd9);

    // 15 idle cycles in FETCH -> FAULT, sticky
    for (int i = 0; i < 14; i++) cyc();
    #1 check("to_still_fetch", 32'(State), 32'(ST_FETCH));
    cyc();
    #1 check("to_fault_state", 32'(State), 32'(ST_FAULT));
    check("to_fault_flag", 32'(Fault), 32'd1);
    check("to_fault_memreq", 32'(Mem_Req), 32'd0);
    Mem_Ready = 1'b1;
    cyc();
    #1 check("to_fault_sticky", 32'(State), 32'(ST_FAULT));
    check("to_fault_irw", 32'(IR_Write), 32'd0);
    Mem_Ready = 1'b0;
    do_reset();
    #1 check("fault_rst_state", 32'(State), 32'(ST_FETCH));
    check("fault_rst_flag", 32'(Fault), 32'd0);
    check("fault_rst_count", 32'(Instr_Count), 32'd0);

    // reset mid-MEM of a store after one completed store
    for (int k = 0; k < 2; k++) begin
      fetch_ok(OP_STORE);
      cyc();
      cyc();
      Mem_Ready = (k == 0);
      #1 check("mr_mem_wr", 32'(Mem_Write), 32'd1);
      if (k == 0) begin
        cyc();
        Mem_Ready = 1'b0;
        #1 check("mr_count1", 32'(Instr_Count), 32'd1);
      end else begin
        rst = 1'b1;
        #1 check("mr_rst_wr", 32'(Mem_Write), 32'd0);
        cyc();
        rst = 1'b0;
        #1 check("mr_state", 32'(State), 32'(ST_FETCH));
        check("mr_count0", 32'(Instr_Count), 32'd0);
        check("mr_no_wr", 32'(Mem_Write), 32'd0);
      end
    end

    // HALT: no requests for 20 cycles whatever Mem_Ready does
    fetch_ok(OP_HALT);
    cyc();
    #1 check("halt_state", 32'(State), 32'(ST_HALT));
    check("halt_flag", 32'(Halted), 32'd1);
    req_seen = 0;
    for (int i = 0; i < 20; i++) begin
      Mem_Ready = i[0];
      #1 if (Mem_Req || IR_Write || PC_Write || Reg_Write || Mem_Write) req_seen++;
      cyc();
    end
    Mem_Ready = 1'b0;
    check("halt_quiet", 32'(req_seen), 32'd0);
    check("halt_sticky", 32'(State), 32'(ST_HALT));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1 check("halt_rst_state", 32'(State), 32'(ST_FETCH));
    check("halt_rst_flag", 32'(Halted), 32'd0);
    check("halt_rst_memreq", 32'(Mem_Req), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_cycle_controller.md
MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 Parameter: MEM_TIMEOUT, 15, max wait cycles for Mem_Ready per memory access before fault (1..255).
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 Op_Code  input  4  opcode field of the instruction register, valid from DECODE onward.
REQ-006 Zero  input  1  ALU zero flag, sampled in BRANCH.
REQ-007 Mem_Ready  input  1  memory completion strobe for the current request.
REQ-008 Mem_Req  output  1  memory request, held high until Mem_Ready or timeout.
REQ-009 Mem_Read / Mem_Write  output  1 each  access direction qualifying Mem_Req.
REQ-010 IorD  output  1  address select: 0 = PC, 1 = ALU result.
REQ-011 IR_Write, PC_Write, Reg_Write  output  1 each  single-cycle write enables.
REQ-012 ALU_Op  output  3  ALU function select.
REQ-013 State  output  3  current FSM state encoding.
REQ-014 Halted, Fault  output  1 each  sticky status flags.
REQ-015 Instr_Count  output  16  retired-instruction counter.

Function
REQ-016 The FSM SHALL have states FETCH, DECODE, EXEC, WB, ADDR, MEM, BRANCH, HALT, FAULT (FAULT may share an encoding slot only if State stays distinguishable; use 4 bits if needed).
REQ-017 FETCH: Mem_Req=1, Mem_Read=1, IorD=0; on Mem_Ready assert IR_Write and PC_Write (PC+1) in that same cycle, then go to DECODE.
REQ-018 DECODE: 1111 -> HALT; 1001 -> BRANCH; 1000 (load) or 1010 (store) -> ADDR; all others -> EXEC.
REQ-019 EXEC: ALU_Op from the table 0010->2, 0100->6, 0101->3, 0110->5, 1011->0, 1100->4, 1101->7, else 1; next state WB.
REQ-020 WB: Reg_Write=1 for exactly one cycle, Instr_Count increments, then FETCH.
REQ-021 ADDR: ALU_Op=1 (add); next state MEM.
REQ-022 MEM: Mem_Req=1, IorD=1, Mem_Read for load / Mem_Write for store; on Mem_Ready a load goes to WB and a store increments Instr_Count and goes to FETCH.
REQ-023 BRANCH: ALU_Op=6; PC_Write=Zero; Instr_Count increments; next state FETCH.
REQ-024 Latency with Mem_Ready on first request cycle: ALU 4 cycles, load 5, store 4, branch 3, FETCH through retire.
REQ-025 Wait counter SHALL clear on entering FETCH/MEM and increment each cycle Mem_Ready is low; when it reaches MEM_TIMEOUT with Mem_Ready still low, go to FAULT.
REQ-026 Mem_Ready in the same cycle the counter hits MEM_TIMEOUT SHALL count as completion, not fault.
REQ-027 Mem_Ready outside FETCH/MEM SHALL be ignored.
REQ-028 HALT: Halted=1, all enables 0; remain until rst.
REQ-029 FAULT: Fault=1, all enables 0; remain until rst.
REQ-030 Instr_Count SHALL saturate at 16'hFFFF.
REQ-031 All outputs other than State, Halted, Fault, Instr_Count SHALL be Moore-decoded from state, plus Mem_Ready/Zero where stated.

Reset
REQ-032 rst SHALL force FETCH and clear the wait counter, Instr_Count, Halted and Fault; it overrides every transition, including mid-MEM.
REQ-033 All enables SHALL be 0 and ALU_Op 1 during the reset cycle; Mem_Req rises in the first cycle after rst deasserts.

Structure
REQ-034 Package ctrl_pkg SHALL hold the state encoding, opcode constants (HALT, BRANCH, LOAD, STORE) and the ALU_Op table constants.
REQ-035 Sub-module alu_op_decode SHALL hold the combinational Op_Code -> ALU_Op table used in EXEC.

Verification
REQ-036 ALU op 0100, Mem_Ready immediate -> ALU_Op=6 in EXEC, one Reg_Write pulse, Instr_Count 0->1, 4 cycles.
REQ-037 Load 1000 with Mem_Ready delayed 3 cycles in MEM -> Mem_Req held 4 cycles with IorD=1, Reg_Write in following cycle, 8 cycles total.
REQ-038 Branch 1001 with Zero=1, then Zero=0 -> PC_Write pulses once in BRANCH, then no PC_Write in BRANCH.
REQ-039 Mem_Ready held low in FETCH, MEM_TIMEOUT=15 -> FAULT after 15 wait cycles; Mem_Ready on cycle 15 -> normal DECODE instead.
REQ-040 Op_Code 1111 -> HALT, Halted=1, Mem_Req stays 0 for 20 cycles; rst -> FETCH, Halted=0.
REQ-041 rst asserted mid-MEM for a store -> no Mem_Write after reset, Instr_Count=0, State=FETCH.
